// File: rtl/t_codec_pkg.sv
// ---------------------------------------------------------------------------
// t_codec_pkg
// Shared definitions for the T-flip-flop line codec (decoder and encoder).
//   t_state_e : frame state machine states (IDLE, DATA, PARITY, STOP)
//   START_T   : T bit value of a start bit (a line toggle)
//   STOP_T    : T bit value of a stop bit (no line toggle)
// ---------------------------------------------------------------------------
package t_codec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } t_state_e;

  localparam logic START_T = 1'b1;
  localparam logic STOP_T  = 1'b0;

endpackage

// File: rtl/t_edge_decode.sv
// ---------------------------------------------------------------------------
// t_edge_decode
// Recovers one T bit per bit strobe from the encoded line: a line change
// since the previous strobe is a 1, no change is a 0.
// Ports:
//   clk     in  clock, posedge
//   rst     in  synchronous active-high reset (previous line value -> 0)
//   bit_en  in  bit strobe; the line is sampled only when high
//   q_in    in  encoded line
//   t       out decoded T bit (combinational, meaningful when t_valid)
//   t_valid out high on strobe cycles, qualifies t
// ---------------------------------------------------------------------------
module t_edge_decode (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic q_in,
  output logic t,
  output logic t_valid
);

  // Line value seen at the previous strobe. Resets to 0 to match the
  // transmitter's T flip-flop, which also comes out of reset with Q=0.
  logic q_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_prev <= 1'b0;
    end else if (bit_en) begin
      q_prev <= q_in;
    end
  end

  assign t       = q_in ^ q_prev;
  assign t_valid = bit_en;

endmodule

// File: rtl/t_decode_deser.sv
// ---------------------------------------------------------------------------
// t_decode_deser
// Receive end of a T-flip-flop line encoder: decodes T bits from the line,
// frames start / payload / (parity) / stop, and presents parallel words.
//
// Optional feature macro: T_DECODE_PARITY_EN
//   defined   : one even-parity T bit follows the payload; a parity
//               mismatch gives frame_err instead of data_valid.
//   undefined : frame is start + payload + stop only.
//
// Parameters:
//   DATA_W     payload bits per frame (1..32)
// Ports:
//   clk        in  clock, posedge
//   rst        in  synchronous active-high reset
//   bit_en     in  bit strobe; one T bit decoded per strobe
//   q_in       in  encoded line
//   t_out      out last decoded T bit, registered
//   data       out last good payload (LSB first on the line), held
//   data_valid out one-cycle pulse, good frame received
//   frame_err  out one-cycle pulse, bad stop bit (or parity)
//   busy       out high whenever the FSM is not IDLE
//   fsm_state  out current FSM state, for observation
//
// Output handshake: there is no back-pressure. data_valid is a one-clock
// pulse and data is valid from that cycle until the next good frame; the
// consumer must take the word whenever data_valid is high.
// ---------------------------------------------------------------------------
module t_decode_deser
  import t_codec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              q_in,
  output logic              t_out,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output t_state_e          fsm_state
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Decoded T bit stream
  logic t;
  logic t_valid;

  t_edge_decode u_edge_decode (
    .clk     (clk),
    .rst     (rst),
    .bit_en  (bit_en),
    .q_in    (q_in),
    .t       (t),
    .t_valid (t_valid)
  );

  // Frame state
  t_state_e          state;
  t_state_e          state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic [DATA_W-1:0] data_n;
  logic [DATA_W-1:0] t_msb;
  logic              par_bad;
  logic              par_bad_n;
  logic              valid_n;
  logic              err_n;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      t_out      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      par_bad    <= par_bad_n;
      data       <= data_n;
      // Pulses are recomputed every clock, so they drop after one cycle
      // even when the strobes are sparse.
      data_valid <= valid_n;
      frame_err  <= err_n;
      if (t_valid) begin
        t_out <= t;
      end
    end
  end

  // Next-state and datapath logic; nothing moves on non-strobe cycles.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    data_n    = data;
    valid_n   = 1'b0;
    err_n     = 1'b0;

    // New bit enters at the MSB; after DATA_W shifts the first (LSB-first)
    // line bit has walked down to shreg[0].
    t_msb             = '0;
    t_msb[DATA_W-1]   = t;

    if (t_valid) begin
      case (state)
        IDLE: begin
          if (t == START_T) begin
            state_n   = DATA;
            cnt_n     = '0;
            shreg_n   = '0;
            par_bad_n = 1'b0;
          end
        end

        DATA: begin
          shreg_n = (shreg >> 1) | t_msb;
          cnt_n   = cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
`ifdef T_DECODE_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end

        PARITY: begin
`ifdef T_DECODE_PARITY_EN
          // Even parity over payload plus parity bit: the parity T bit
          // must equal the XOR of the payload bits.
          if (t != ^shreg) begin
            par_bad_n = 1'b1;
          end
          state_n = STOP;
`else
          state_n = IDLE;
`endif
        end

        STOP: begin
          if ((t == STOP_T) && !par_bad) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n   = 1'b1;
          end
          state_n = IDLE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_t_decode_deser.sv
// ---------------------------------------------------------------------------
// tb_t_decode_deser
// Directed bench for t_decode_deser (DATA_W=8). A frame-level model tracks
// the line, collects T bits per frame and decides the outcome; a compare
// process checks every output on every falling edge. Literal expectations
// after each scenario pin the model. Builds with or without
// T_DECODE_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_t_decode_deser;
  import t_codec_pkg::*;

  localparam int DATA_W = 8;
`ifdef T_DECODE_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic bit_en = 1'b0;
  logic q_in   = 1'b0;

  always #5 clk = ~clk;

  logic              t_out;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              frame_err;
  logic              busy;
  t_state_e          fsm_state;

  t_decode_deser #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .q_in       (q_in),
    .t_out      (t_out),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [DATA_W-1:0] exp_q[$];   // words the model expects on data_valid
  logic              fb_q[$];    // T bits of the frame after its start bit
  logic              m_q_prev = 1'b0;
  logic              m_t_out  = 1'b0;
  logic [DATA_W-1:0] m_data   = '0;
  logic              m_valid  = 1'b0;
  logic              m_err    = 1'b0;
  bit                m_in_frame = 1'b0;
  logic              m_t;
  logic [DATA_W-1:0] m_w;
  int                m_ones;
  bit                m_ok;

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_q_prev   = 1'b0;
      m_t_out    = 1'b0;
      m_data     = '0;
      m_in_frame = 1'b0;
      fb_q.delete();
    end else if (bit_en) begin
      m_t      = q_in ^ m_q_prev;
      m_q_prev = q_in;
      m_t_out  = m_t;
      if (!m_in_frame) begin
        if (m_t) begin
          m_in_frame = 1'b1;
          fb_q.delete();
        end
      end else begin
        fb_q.push_back(m_t);
        if (fb_q.size() == DATA_W + PAR_BITS + 1) begin
          m_w    = '0;
          m_ones = 0;
          for (int i = 0; i < DATA_W; i++) begin
            m_w[i] = fb_q[i];
            m_ones += int'(fb_q[i]);
          end
          m_ok = (fb_q[DATA_W + PAR_BITS] == 1'b0);
          if (PAR_BITS == 1) begin
            m_ok = m_ok && (((m_ones + int'(fb_q[DATA_W])) % 2) == 0);
          end
          if (m_ok) begin
            m_data  = m_w;
            m_valid = 1'b1;
            exp_q.push_back(m_w);
          end else begin
            m_err = 1'b1;
          end
          m_in_frame = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("t_out",      t_out,      m_t_out);
      check("data",       data,       m_data);
      check("data_valid", data_valid, m_valid);
      check("frame_err",  frame_err,  m_err);
      check("busy",       busy,       m_in_frame);
      check("state_idle", fsm_state == IDLE, !m_in_frame);
      if (data_valid) begin
        dv_cnt++;
        check("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("sb_word", data, exp_q.pop_front());
      end
      if (frame_err) fe_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  logic line = 1'b0;   // transmitter T flip-flop Q

  task automatic drive(input logic be, input logic q);
    @(posedge clk);
    #1;
    bit_en = be;
    q_in   = q;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, q_in);
  endtask

  // One T bit with `gap` non-strobe cycles after it; the line is flipped
  // during the gap so any sampling between strobes would show up.
  task automatic send_t(input logic t, input int gap);
    line = line ^ t;
    drive(1'b1, line);
    repeat (gap) drive(1'b0, ~line);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] word, input logic par_flip,
                            input logic stop_t, input int gap);
    send_t(START_T, gap);
    for (int i = 0; i < DATA_W; i++) send_t(word[i], gap);
`ifdef T_DECODE_PARITY_EN
    send_t((^word) ^ par_flip, gap);
`endif
    send_t(stop_t, gap);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst    = 1'b1;
      bit_en = 1'b1;
      q_in   = ~q_in;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] lv_a5 = 10'b1100111001;  // line for 0xA5, first sample in bit 0

  initial begin
    // Reset with the line toggling and strobes active
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset(2);
    @(negedge clk);
    check("rst_data",       data,       8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_err",  frame_err,  1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_t_out",      t_out,      1'b0);
    // Release; first strobe with q_in=0 decodes T=0
    @(posedge clk);
    #1;
    rst = 1'b0; bit_en = 1'b1; q_in = 1'b0;
    line = 1'b0;
    drive(1'b0, 1'b0);
    @(negedge clk);
    check("first_t_out", t_out, 1'b0);

    // Good 0xA5 frame
`ifdef T_DECODE_PARITY_EN
    send_frame(8'hA5, 1'b0, STOP_T, 0);
`else
    for (int i = 0; i < 10; i++) drive(1'b1, lv_a5[i]);
    line = lv_a5[9];
`endif
    idle(2);
    check("a5_data",   data,   8'hA5);
    check("a5_dv_cnt", dv_cnt, 1);
    check("a5_fe_cnt", fe_cnt, 0);

    // Bad stop bit: error pulse, data held, back to IDLE
    send_frame(8'h5C, 1'b0, 1'b1, 0);
    idle(2);
    check("badstop_fe_cnt", fe_cnt, 1);
    check("badstop_data",   data,   8'hA5);
    check("badstop_idle",   fsm_state == IDLE, 1'b1);

    send_frame(8'h3C, 1'b0, STOP_T, 0);
    idle(2);
    check("3c_data",   data,   8'h3C);
    check("3c_dv_cnt", dv_cnt, 2);

    // Back-to-back frames, start directly after stop
    send_frame(8'hC3, 1'b0, STOP_T, 0);
    send_frame(8'h81, 1'b0, STOP_T, 0);
    idle(2);
    check("b2b_data",   data,   8'h81);
    check("b2b_dv_cnt", dv_cnt, 4);

    // Sparse strobes: every 4th cycle
    send_frame(8'hA5, 1'b0, STOP_T, 3);
    idle(3);
    check("sparse_data",   data,   8'hA5);
    check("sparse_dv_cnt", dv_cnt, 5);

    // Reset after 4 payload bits, then a full 0x5A frame
    send_t(START_T, 0);
    send_t(1'b1, 0);
    send_t(1'b0, 0);
    send_t(1'b1, 0);
    send_t(1'b1, 0);
    do_reset(2);
    @(posedge clk);
    #1;
    rst = 1'b0; bit_en = 1'b0; q_in = 1'b0;
    line = 1'b0;
    idle(1);
    check("midrst_dv_cnt", dv_cnt, 5);
    check("midrst_data",   data,   8'h00);
    send_frame(8'h5A, 1'b0, STOP_T, 0);
    idle(2);
    check("5a_data",   data,   8'h5A);
    check("5a_dv_cnt", dv_cnt, 6);
    check("5a_fe_cnt", fe_cnt, 1);

`ifdef T_DECODE_PARITY_EN
    // Correct parity (0xA5 has four ones -> parity T=0)
    send_frame(8'hA5, 1'b0, STOP_T, 0);
    idle(2);
    check("par_ok_data",   data,   8'hA5);
    check("par_ok_dv_cnt", dv_cnt, 7);
    // Wrong parity: error, no data update
    send_frame(8'h0F, 1'b1, STOP_T, 0);
    idle(2);
    check("par_bad_fe_cnt", fe_cnt, 2);
    check("par_bad_data",   data,   8'hA5);
    // Odd payload with parity T=1 is good
    send_frame(8'h07, 1'b0, STOP_T, 0);
    idle(2);
    check("par_odd_data", data, 8'h07);
`endif

    idle(2);
    check("sb_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
